// File: rtl/aclk_setter_pkg.sv
// Shared types and limits for the alarm-clock button setter.
package aclk_setter_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_EDIT_H, ST_EDIT_M, ST_LOAD} setter_state_e;
    typedef enum logic {TGT_TIME, TGT_ALARM} setter_tgt_e;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

endpackage

// File: rtl/aclk_setter_debounce.sv
// Button debouncer: one-cycle press pulse after CYCLES consecutive high samples,
// plus a debounced level that stays high while the button is held.
module aclk_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          armed;

    // A single low sample reloads the counter and re-arms the next press.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= CNT_LOAD;
            armed <= 1'b1;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (!din) begin
                cnt   <= CNT_LOAD;
                armed <= 1'b1;
                level <= 1'b0;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (armed) begin
                press <= 1'b1;
                armed <= 1'b0;
                level <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/aclk_setter.sv
// Button-driven time/alarm setter feeding the aclock config inputs.
// Optional auto-repeat on a held inc button: define ACLK_SETTER_AUTO_REPEAT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for time/alarm button
// ST_EDIT_H | editing hours
// ST_EDIT_M | editing minutes
// ST_LOAD   | strobing LD_time or LD_alarm for LD_CYCLES clocks
module aclk_setter
    import aclk_setter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int LD_CYCLES       = 2
`ifdef ACLK_SETTER_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_inc,
    input  logic       btn_next,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       editing,
    output logic       edit_min
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LW = (LD_CYCLES > 1) ? $clog2(LD_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LD_LOAD  = LW'(LD_CYCLES - 1);

    function automatic logic [5:0] inc_hours(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'(HOUR_MAX / 10) && u == 4'(HOUR_MAX % 10))
            return 6'd0;
        else if (u == 4'd9)
            return {t + 2'd1, 4'd0};
        else
            return {t, u + 4'd1};
    endfunction

    function automatic logic [7:0] inc_minutes(input logic [3:0] t, input logic [3:0] u);
        if (u == 4'd9) begin
            if (t == 4'(MIN_MAX / 10))
                return 8'd0;
            else
                return {t + 4'd1, 4'd0};
        end else begin
            return {t, u + 4'd1};
        end
    endfunction

    logic lvl_time, lvl_alarm, lvl_inc, lvl_next;
    logic prs_time, prs_alarm, prs_inc, prs_next;
    logic rep_fire;

    aclk_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_time (
        .clk(clk), .reset(reset), .din(btn_time), .level(lvl_time), .press(prs_time));
    aclk_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_alarm (
        .clk(clk), .reset(reset), .din(btn_alarm), .level(lvl_alarm), .press(prs_alarm));
    aclk_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .reset(reset), .din(btn_inc), .level(lvl_inc), .press(prs_inc));
    aclk_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .reset(reset), .din(btn_next), .level(lvl_next), .press(prs_next));

    setter_state_e state;
    setter_tgt_e   tgt;
    logic [TW-1:0] tmo_cnt;
    logic [LW-1:0] ld_cnt;

    logic ev_inc, ev_any;
    assign ev_inc = prs_inc | rep_fire;
    assign ev_any = prs_time | prs_alarm | prs_next | ev_inc;

`ifdef ACLK_SETTER_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt;
    logic          in_edit;
    logic          unused_levels;

    assign in_edit       = (state == ST_EDIT_H) || (state == ST_EDIT_M);
    assign rep_fire      = in_edit && lvl_inc && !prs_inc && (rep_cnt == '0);
    assign unused_levels = ^{lvl_time, lvl_alarm, lvl_next};

    // Delay counter starts at the press event, then reloads with the period.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt <= RD_LOAD;
        end else if (prs_inc || !lvl_inc) begin
            rep_cnt <= RD_LOAD;
        end else if (rep_fire) begin
            rep_cnt <= RP_LOAD;
        end else if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt - 1'b1;
        end
    end
`else
    logic unused_levels;
    assign rep_fire      = 1'b0;
    assign unused_levels = ^{lvl_time, lvl_alarm, lvl_inc, lvl_next};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tgt      <= TGT_TIME;
            tmo_cnt  <= TMO_LOAD;
            ld_cnt   <= LD_LOAD;
            H_in1    <= '0;
            H_in0    <= '0;
            M_in1    <= '0;
            M_in0    <= '0;
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
            editing  <= 1'b0;
            edit_min <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= TMO_LOAD;
                    if (prs_time) begin
                        state    <= ST_EDIT_H;
                        tgt      <= TGT_TIME;
                        editing  <= 1'b1;
                        edit_min <= 1'b0;
                    end else if (prs_alarm) begin
                        state    <= ST_EDIT_H;
                        tgt      <= TGT_ALARM;
                        editing  <= 1'b1;
                        edit_min <= 1'b0;
                    end
                end

                ST_EDIT_H: begin
                    if (ev_any) tmo_cnt <= TMO_LOAD;
                    else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

                    if (prs_next) begin
                        state    <= ST_EDIT_M;
                        edit_min <= 1'b1;
                    end else if (ev_inc) begin
                        {H_in1, H_in0} <= inc_hours(H_in1, H_in0);
                    end else if (!ev_any && tmo_cnt == '0) begin
                        state   <= ST_IDLE;
                        editing <= 1'b0;
                    end
                end

                ST_EDIT_M: begin
                    if (ev_any) tmo_cnt <= TMO_LOAD;
                    else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

                    if (prs_next) begin
                        state    <= ST_LOAD;
                        editing  <= 1'b0;
                        edit_min <= 1'b0;
                        ld_cnt   <= LD_LOAD;
                        LD_time  <= (tgt == TGT_TIME);
                        LD_alarm <= (tgt == TGT_ALARM);
                    end else if (ev_inc) begin
                        {M_in1, M_in0} <= inc_minutes(M_in1, M_in0);
                    end else if (!ev_any && tmo_cnt == '0) begin
                        state    <= ST_IDLE;
                        editing  <= 1'b0;
                        edit_min <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (ld_cnt == '0) begin
                        state    <= ST_IDLE;
                        LD_time  <= 1'b0;
                        LD_alarm <= 1'b0;
                    end else begin
                        ld_cnt <= ld_cnt - 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    LD_time  <= 1'b0;
                    LD_alarm <= 1'b0;
                    editing  <= 1'b0;
                    edit_min <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aclk_setter.sv
// Directed bench for aclk_setter: vector tables for edit sequences plus hand-written
// commit, glitch, timeout, reset-in-LOAD and hold-to-repeat sequences.
module tb_aclk_setter;

    localparam int DB  = 4;
    localparam int TMO = 200;
    localparam int LDC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_time = 1'b0, btn_alarm = 1'b0, btn_inc = 1'b0, btn_next = 1'b0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, editing, edit_min;

    aclk_setter #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES(TMO),
        .LD_CYCLES(LDC)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_time(btn_time), .btn_alarm(btn_alarm), .btn_inc(btn_inc), .btn_next(btn_next),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .editing(editing), .edit_min(edit_min)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {B_TIME, B_ALARM, B_INC, B_NEXT} btn_e;

    typedef struct {
        btn_e       btn;
        int         reps;
        logic [5:0] exp_h;
        logic [7:0] exp_m;
        logic       exp_ed;
        logic       exp_min;
        string      name;
    } vec_t;

    vec_t va[10];
    vec_t vb[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_btn(input btn_e b, input logic v);
        case (b)
            B_TIME:  btn_time  = v;
            B_ALARM: btn_alarm = v;
            B_INC:   btn_inc   = v;
            default: btn_next  = v;
        endcase
    endtask

    task automatic press(input btn_e b);
        @(negedge clk);
        set_btn(b, 1'b1);
        repeat (DB) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // {hours, minutes, editing, edit_min, LD_time, LD_alarm}
    function automatic logic [31:0] outs();
        return 32'({H_in1, H_in0, M_in1, M_in0, editing, edit_min, LD_time, LD_alarm});
    endfunction

    function automatic logic [31:0] want(input logic [5:0] h, input logic [7:0] m,
                                         input logic ed, input logic mn);
        return 32'({h, m, ed, mn, 2'b00});
    endfunction

    task automatic run_vec(input vec_t v);
        for (int r = 0; r < v.reps; r++) press(v.btn);
        check(v.name, outs(), want(v.exp_h, v.exp_m, v.exp_ed, v.exp_min));
    endtask

    task automatic commit(input logic is_time, input string name);
        int nt, na, both;
        nt = 0; na = 0; both = 0;
        @(negedge clk);
        btn_next = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == DB - 1) btn_next = 1'b0;
            nt += int'(LD_time);
            na += int'(LD_alarm);
            if (LD_time && LD_alarm) both++;
        end
        check({name, "_ld_time_cycles"},  nt, is_time ? LDC : 0);
        check({name, "_ld_alarm_cycles"}, na, is_time ? 0 : LDC);
        check({name, "_strobes_overlap"}, both, 0);
    endtask

    initial begin
        int  k;
        logic seen;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   k;
        logic seen;

        va[0] = '{B_INC,  1,  6'h00, 8'h00, 1'b0, 1'b0, "idle_inc_ignored"};
        va[1] = '{B_NEXT, 1,  6'h00, 8'h00, 1'b0, 1'b0, "idle_next_ignored"};
        va[2] = '{B_TIME, 1,  6'h00, 8'h00, 1'b1, 1'b0, "enter_time_edit"};
        va[3] = '{B_INC,  6,  6'h06, 8'h00, 1'b1, 1'b0, "hours_06"};
        va[4] = '{B_INC,  3,  6'h09, 8'h00, 1'b1, 1'b0, "hours_09"};
        va[5] = '{B_INC,  1,  6'h10, 8'h00, 1'b1, 1'b0, "hours_09_to_10"};
        va[6] = '{B_INC,  3,  6'h13, 8'h00, 1'b1, 1'b0, "hours_13"};
        va[7] = '{B_NEXT, 1,  6'h13, 8'h00, 1'b1, 1'b1, "to_minutes"};
        va[8] = '{B_INC,  7,  6'h13, 8'h07, 1'b1, 1'b1, "minutes_07"};
        va[9] = '{B_TIME, 1,  6'h13, 8'h07, 1'b1, 1'b1, "time_in_edit_ignored"};

        vb[0] = '{B_ALARM, 1,  6'h13, 8'h07, 1'b1, 1'b0, "enter_alarm_keeps_value"};
        vb[1] = '{B_INC,   6,  6'h19, 8'h07, 1'b1, 1'b0, "hours_19"};
        vb[2] = '{B_INC,   1,  6'h20, 8'h07, 1'b1, 1'b0, "hours_19_to_20"};
        vb[3] = '{B_INC,   2,  6'h22, 8'h07, 1'b1, 1'b0, "hours_22"};
        vb[4] = '{B_INC,   2,  6'h00, 8'h07, 1'b1, 1'b0, "hours_22_wrap_00"};
        vb[5] = '{B_NEXT,  1,  6'h00, 8'h07, 1'b1, 1'b1, "alarm_to_minutes"};
        vb[6] = '{B_INC,  51,  6'h00, 8'h58, 1'b1, 1'b1, "minutes_58"};
        vb[7] = '{B_INC,   1,  6'h00, 8'h59, 1'b1, 1'b1, "minutes_59"};
        vb[8] = '{B_INC,   1,  6'h00, 8'h00, 1'b1, 1'b1, "minutes_59_wrap_00"};

        // reset state
        repeat (3) @(negedge clk);
        check("reset_state", outs(), want(6'h00, 8'h00, 1'b0, 1'b0));
        reset = 1'b0;

        // clock time edit and commit
        for (int i = 0; i < 10; i++) run_vec(va[i]);
        commit(1'b1, "commit_time");
        check("after_time_commit", outs(), want(6'h13, 8'h07, 1'b0, 1'b0));

        // alarm edit with hour and minute wrap, commit
        for (int i = 0; i < 9; i++) run_vec(vb[i]);
        commit(1'b0, "commit_alarm");
        check("after_alarm_commit", outs(), want(6'h00, 8'h00, 1'b0, 1'b0));

        // timeout in EDIT_M keeps the edited value and strobes nothing
        press(B_TIME);
        press(B_INC);
        press(B_NEXT);
        check("pre_timeout", outs(), want(6'h01, 8'h00, 1'b1, 1'b1));
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            seen |= LD_time | LD_alarm;
        end
        check("still_editing_150", editing, 1'b1);
        k = 0;
        while (editing && k < 100) begin
            @(negedge clk);
            seen |= LD_time | LD_alarm;
            k++;
        end
        check("timeout_exit", outs(), want(6'h01, 8'h00, 1'b0, 1'b0));
        check("timeout_no_strobe", seen, 1'b0);

        // reset during the first LOAD cycle
        press(B_TIME);
        press(B_NEXT);
        @(negedge clk);
        btn_next = 1'b1;
        k = 0;
        while (!LD_time && k < 20) begin
            @(negedge clk);
            k++;
            if (k == DB) btn_next = 1'b0;
        end
        btn_next = 1'b0;
        check("load_reached", LD_time, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_load", outs(), want(6'h00, 8'h00, 1'b0, 1'b0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // short glitches never register; a full-length press increments once
        press(B_TIME);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (DB - 1) @(negedge clk);
        btn_inc = 1'b0;
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (DB - 1) @(negedge clk);
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_no_inc", outs(), want(6'h00, 8'h00, 1'b1, 1'b0));
        press(B_INC);
        check("full_press_one_inc", outs(), want(6'h01, 8'h00, 1'b1, 1'b0));

        // hold inc for 100 clocks past the press event in EDIT_M
        press(B_NEXT);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (DB + 100) @(negedge clk);
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
`ifdef ACLK_SETTER_AUTO_REPEAT_EN
        check("hold_inc_minutes", outs(), want(6'h01, 8'h04, 1'b1, 1'b1));
`else
        check("hold_inc_minutes", outs(), want(6'h01, 8'h01, 1'b1, 1'b1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
